simon_pattern_display: RTL and testbench

- Pattern-and-display unit for the Simon-Says game.
- Maps a game seed and two sequence indices (show pointer, player pointer) to deterministic LED codes 0..3.
- Decodes three 6-bit counters (show pointer, player pointer, level) to 7-segment glyphs.
- Sits between the game controller and the board LEDs/displays. All outputs are registered.

---
 rtl/simon_pattern_display_pkg.sv | 29 ++
 rtl/simon_pattern_display_if.sv | 25 ++
 rtl/simon_pattern_display_seg7_hex_decoder.sv | 11 +
 rtl/simon_pattern_display.sv | 54 +++++
 tb/tb_simon_pattern_display.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/simon_pattern_display_pkg.sv
// Shared constants, types and the pattern hash for the Simon-Says pattern/display unit.
package simon_pkg;

  localparam int SEED_W   = 5;
  localparam int IDX_W    = 6;
  localparam int MUL_SEED = 37;
  localparam int MUL_IDX  = 13;

  typedef logic [2:0] led_code_t;

  // Active-low {g,f,e,d,c,b,a}; element 0 is the glyph for digit 0.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // 8-bit wrapping hash; the LED code folds two 2-bit fields of the sum together.
  function automatic led_code_t pattern_hash(input logic [SEED_W-1:0] seed,
                                             input logic [IDX_W-1:0]  idx);
    logic [7:0] v;
    v = 8'(seed) * 8'(MUL_SEED) + 8'(idx) * 8'(MUL_IDX);
    return {1'b0, v[3:2] ^ v[5:4]};
  endfunction

endpackage

// File: rtl/simon_pattern_display_if.sv
// Bundle between the game controller (master) and the pattern/display unit (slave).
interface simon_pattern_display_if;
  import simon_pkg::*;

  logic [SEED_W-1:0] seq_no;
  logic [IDX_W-1:0]  show_idx;
  logic [IDX_W-1:0]  play_idx;
  logic [IDX_W-1:0]  level;
  led_code_t         show_code;
  led_code_t         play_code;
  logic [6:0]        seg_show;
  logic [6:0]        seg_play;
  logic [6:0]        seg_level;

  modport master (
    output seq_no, show_idx, play_idx, level,
    input  show_code, play_code, seg_show, seg_play, seg_level
  );

  modport slave (
    input  seq_no, show_idx, play_idx, level,
    output show_code, play_code, seg_show, seg_play, seg_level
  );

endinterface

// File: rtl/simon_pattern_display_seg7_hex_decoder.sv
// Combinational hex-digit to active-low 7-segment glyph lookup.
module seg7_hex_decoder
  import simon_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = SEG_GLYPH[digit];

endmodule

// File: rtl/simon_pattern_display.sv
// Simon-Says pattern and display unit: registered LED codes and 7-segment glyphs.
// Define SEG_ACTIVE_HIGH_EN to drive all segment outputs active-high.
module simon_pattern_display
  import simon_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  simon_pattern_display_if.slave  bus
);

`ifdef SEG_ACTIVE_HIGH_EN
  localparam logic [6:0] SEG_POL = 7'b1111111;
`else
  localparam logic [6:0] SEG_POL = 7'b0000000;
`endif

  logic [6:0] glyph_show;
  logic [6:0] glyph_play;
  logic [6:0] glyph_level;

  led_code_t  show_code_p1;
  led_code_t  play_code_p1;
  logic [6:0] seg_show_p1;
  logic [6:0] seg_play_p1;
  logic [6:0] seg_level_p1;

  seg7_hex_decoder u_dec_show  (.digit(bus.show_idx[3:0]), .seg(glyph_show));
  seg7_hex_decoder u_dec_play  (.digit(bus.play_idx[3:0]), .seg(glyph_play));
  seg7_hex_decoder u_dec_level (.digit(bus.level[3:0]),    .seg(glyph_level));

  // Stage p0 -> p1: single output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      show_code_p1 <= '0;
      play_code_p1 <= '0;
      seg_show_p1  <= SEG_BLANK ^ SEG_POL;
      seg_play_p1  <= SEG_BLANK ^ SEG_POL;
      seg_level_p1 <= SEG_BLANK ^ SEG_POL;
    end else begin
      show_code_p1 <= pattern_hash(bus.seq_no, bus.show_idx);
      play_code_p1 <= pattern_hash(bus.seq_no, bus.play_idx);
      seg_show_p1  <= glyph_show  ^ SEG_POL;
      seg_play_p1  <= glyph_play  ^ SEG_POL;
      seg_level_p1 <= glyph_level ^ SEG_POL;
    end
  end

  assign bus.show_code = show_code_p1;
  assign bus.play_code = play_code_p1;
  assign bus.seg_show  = seg_show_p1;
  assign bus.seg_play  = seg_play_p1;
  assign bus.seg_level = seg_level_p1;

endmodule

// File: tb/tb_simon_pattern_display.sv
// Scoreboard bench for simon_pattern_display: stimulus pushes expectations, monitor pops and compares.
module tb_simon_pattern_display;
  import simon_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  simon_pattern_display_if bus ();

  simon_pattern_display dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    led_code_t  show_code;
    led_code_t  play_code;
    logic [6:0] seg_show;
    logic [6:0] seg_play;
    logic [6:0] seg_level;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Polarity applied to every hand-written active-low segment value
  function automatic logic [6:0] pol(input logic [6:0] s);
`ifdef SEG_ACTIVE_HIGH_EN
    return ~s;
`else
    return s;
`endif
  endfunction

  function automatic logic [6:0] glyph(input logic [IDX_W-1:0] val);
    logic [6:0] s;
    case (val[3:0])
      4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;  default: s = 7'b0001110;
    endcase
    return pol(s);
  endfunction

  function automatic led_code_t model_code(input int seed, input int idx);
    int v;
    int lo;
    int hi;
    v  = (seed * 37 + idx * 13) % 256;
    lo = (v / 4) % 4;
    hi = (v / 16) % 4;
    return 3'(lo ^ hi);
  endfunction

  task automatic drive(input logic r, input int seed, input int sidx, input int pidx, input int lvl);
    @(negedge clk);
    rst          = r;
    bus.seq_no   = SEED_W'(seed);
    bus.show_idx = IDX_W'(sidx);
    bus.play_idx = IDX_W'(pidx);
    bus.level    = IDX_W'(lvl);
  endtask

  task automatic step_reset(input string nm, input int seed, input int sidx, input int pidx, input int lvl);
    exp_t e;
    drive(1'b1, seed, sidx, pidx, lvl);
    e.name = nm; e.show_code = 3'd0; e.play_code = 3'd0;
    e.seg_show = pol(7'b1111111); e.seg_play = pol(7'b1111111); e.seg_level = pol(7'b1111111);
    q.push_back(e);
  endtask

  task automatic step_hand(input string nm, input int seed, input int sidx, input int pidx, input int lvl,
                           input led_code_t sc, input led_code_t pc, input logic [6:0] seg_lvl_low);
    exp_t e;
    drive(1'b0, seed, sidx, pidx, lvl);
    e.name = nm; e.show_code = sc; e.play_code = pc;
    e.seg_show = glyph(IDX_W'(sidx)); e.seg_play = glyph(IDX_W'(pidx)); e.seg_level = pol(seg_lvl_low);
    q.push_back(e);
  endtask

  task automatic step_model(input string nm, input int seed, input int sidx, input int pidx, input int lvl);
    exp_t e;
    drive(1'b0, seed, sidx, pidx, lvl);
    e.name = nm; e.show_code = model_code(seed, sidx); e.play_code = model_code(seed, pidx);
    e.seg_show = glyph(IDX_W'(sidx)); e.seg_play = glyph(IDX_W'(pidx)); e.seg_level = glyph(IDX_W'(lvl));
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input string fld, input logic [6:0] act, input logic [6:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %b, required %b", nm, fld, act, req);
    end
  endtask

  // Monitor: one expectation per clock, sampled 1 time unit after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "show_code", {4'b0, bus.show_code}, {4'b0, e.show_code});
        chk(e.name, "play_code", {4'b0, bus.play_code}, {4'b0, e.play_code});
        chk(e.name, "seg_show",  bus.seg_show,  e.seg_show);
        chk(e.name, "seg_play",  bus.seg_play,  e.seg_play);
        chk(e.name, "seg_level", bus.seg_level, e.seg_level);
      end
    end
  end

  initial begin
    int budget;
    bus.seq_no = 5'd19; bus.show_idx = 6'd45; bus.play_idx = 6'd7; bus.level = 6'd33;

    step_reset("rst_a", 19, 45, 7, 33);
    step_reset("rst_b", 3, 12, 60, 9);
    step_hand("release", 0, 0, 0, 0, 3'd0, 3'd0, 7'b1000000);

    step_hand("seed1_i0_i1", 1, 0, 1, 5, 3'd3, 3'd3, 7'b0010010);
    step_hand("seed2_i0",    2, 0, 0, 10, 3'd2, 3'd2, 7'b0001000);
    step_hand("seed0_i4",    0, 4, 2, 11, 3'd2, 3'd3, 7'b0000011);
    step_hand("seed0_i2",    0, 2, 2, 15, 3'd3, 3'd3, 7'b0001110);
    step_hand("level17",     0, 0, 0, 17, 3'd0, 3'd0, 7'b1111001);
    step_hand("level26",     0, 0, 0, 26, 3'd0, 3'd0, 7'b0001000);
    step_hand("idx63_wrap",  31, 63, 63, 63, model_code(31, 63), model_code(31, 63), 7'b0001110);

    for (int l = 0; l < 64; l++) step_model("level_sweep", l % 32, l, 63 - l, l);

    for (int s = 0; s < 32; s++)
      for (int i = 0; i < 64; i++) step_model("hash_sweep", s, i, (i * 7 + s) % 64, (i + s) % 64);

    for (int k = 0; k < 3; k++) step_model("repeat", 13, 42, 42, 42);

    // Reset landing in the same cycle as an input change
    step_model("pre_mid", 5, 9, 20, 3);
    step_reset("mid_rst", 27, 50, 11, 44);
    step_model("post_mid", 27, 50, 11, 44);
    step_hand("post_mid2", 1, 0, 1, 12, 3'd3, 3'd3, 7'b1000110);

    budget = 0;
    while (q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    @(negedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
